mem_stage: RTL
==============

Name: mem_stage

Overview:
- Fourth pipeline stage: sits directly downstream of the execute stage, upstream of write-back.
- Accepts the execute-to-memory bus and completes loads using the synchronous data SRAM read data, which returns one cycle after the request issued in execute.
- Holds read data across write-back stalls and forms the final register-write result.
- Forwards the in-flight write target to decode for hazard and bypass logic.

Parameters:
- ES_TO_MS_WD, 71 (74 with SUBWORD_LOAD_EN), width of the input bus from execute.
- MS_TO_WS_WD, 70, width of the output bus to write-back.
- MS_TO_DS_WD, 38, width of the feedback bus to decode.

Ports:
- clk  input  1  Clock.
- reset  input  1  Reset; synchronous, active-high.
- ws_allowin  input  1  Write-back can accept this cycle.
- ms_allowin  output  1  Memory stage can accept this cycle.
- es_to_ms_valid  input  1  Execute offers an instruction.
- es_to_ms_bus  input  ES_TO_MS_WD  {[73:71] load_type (feature only), [70] res_from_mem, [69] gr_we, [68:64] dest, [63:32] result/address, [31:0] pc}.
- ms_to_ws_valid  output  1  Valid to write-back.
- ms_to_ws_bus  output  70  {[69] gr_we, [68:64] dest, [63:32] final_result, [31:0] pc}.
- data_sram_rdata  input  32  SRAM read data; meaningful only in the first cycle a load occupies this stage.
- ms_to_ds_bus  output  38  {[37] we, [36:32] dest, [31:0] final_result}.

Behaviour:
- Registers: ms_valid, bus register, ms_first (first occupancy cycle), rdata_hold[31:0].
- ms_ready_go is constant 1.
- ms_allowin = !ms_valid || ws_allowin.
- ms_to_ws_valid = ms_valid.
- Reset (synchronous): ms_valid=0, ms_first=0, rdata_hold=0, bus register=0. After reset, ms_allowin=1, ms_to_ws_valid=0, and ms_to_ds_bus we=0.
- Update when ms_allowin=1: ms_valid <= es_to_ms_valid.
- Load on es_to_ms_valid && ms_allowin: bus register <= es_to_ms_bus and ms_first <= 1. Otherwise ms_first <= 0.
- Capture: if ms_valid && ms_first, rdata_hold <= data_sram_rdata.
- Effective rdata = ms_first ? data_sram_rdata : rdata_hold. This makes the result stable for any number of ws_allowin=0 cycles.
- final_result = res_from_mem ? load_data(effective rdata) : result.
- ms_to_ds_bus we = ms_valid && gr_we; it is 0 whenever ms_valid=0.
- Back-to-back loads: a new load entering the same cycle the old one leaves sets ms_first again. Rdata is taken live that cycle with no stale hold.
- Bubble: when es_to_ms_valid=0 and ms_allowin=1, ms_valid drops to 0. Bus contents are irrelevant but outputs stay gated.
- Reset mid-stall discards the held instruction. The next cycle shows ms_to_ws_valid=0.
- The stage never drops or duplicates an instruction. Exactly one ms_to_ws_valid && ws_allowin handshake occurs per accepted instruction.

Optional Feature:
- Macro SUBWORD_LOAD_EN.
- Defined:
  - Bus is 74 bits; load_type 0=word, 1=byte signed, 2=byte unsigned, 3=half signed, 4=half unsigned; other codes treated as word.
  - Byte select = result[1:0]; halfword select = result[1] (halfwords are aligned).
  - Extracted data is sign- or zero-extended to 32 bits.
- Undefined: bus is 71 bits; load_data = full 32-bit word.

Test Plan:
- Reset held 2 cycles, then released with es_to_ms_valid=0: ms_allowin=1, ms_to_ws_valid=0, ms_to_ds_bus[37]=0.
- ALU op (res_from_mem=0, gr_we=1, dest=5, result=0x12345678, pc=0x1c000010) with ws_allowin=1: next cycle ms_to_ws_bus={1,5,0x12345678,0x1c000010} and ms_to_ds_bus={1,5,0x12345678}.
- Word load with rdata=0xDEADBEEF in the first cycle and ws_allowin=0 for 3 cycles while rdata changes to 0x0: final_result stays 0xDEADBEEF all 4 cycles, and ms_allowin=0 during the stall.
- Two back-to-back loads (rdata 0x11111111 then 0x22222222) with ws_allowin=1: consecutive outputs are 0x11111111 then 0x22222222, with no repeat.
- With SUBWORD_LOAD_EN: ld.b at address 0x...3 with rdata 0x80FF7F01 gives 0xFFFFFF80; ld.bu gives 0x00000080; ld.h at 0x...2 gives 0xFFFF80FF; ld.hu at 0x...0 gives 0x00007F01.
- Reset asserted during a stalled load: next cycle ms_to_ws_valid=0; a following accepted ALU op passes through correctly.

Source files
------------

// File: rtl/mem_stage_if.sv
// ----------------------------------------------------------------------------
// mem_stage_if
//
// Groups the handshake and bus signals around the memory pipeline stage.
//
//   ws_allowin      write-back can accept an instruction this cycle
//   ms_allowin      memory stage can accept an instruction this cycle
//   es_to_ms_valid  execute offers an instruction
//   es_to_ms_bus    instruction fields from execute
//   ms_to_ws_valid  memory stage presents an instruction to write-back
//   ms_to_ws_bus    {gr_we, dest, final_result, pc} to write-back
//   data_sram_rdata synchronous data SRAM read data (one cycle after request)
//   ms_to_ds_bus    {we, dest, final_result} fed back to decode
//
// Modports:
//   master  the environment around the stage (execute/write-back/SRAM/decode)
//   slave   the memory stage itself
//
// Build option: define SUBWORD_LOAD_EN to widen es_to_ms_bus to 74 bits
// (adds a 3-bit load_type field).
// ----------------------------------------------------------------------------
interface mem_stage_if #(
`ifdef SUBWORD_LOAD_EN
  parameter int ES_TO_MS_WD = 74,
`else
  parameter int ES_TO_MS_WD = 71,
`endif
  parameter int MS_TO_WS_WD = 70,
  parameter int MS_TO_DS_WD = 38
);

  logic                   ws_allowin;
  logic                   ms_allowin;
  logic                   es_to_ms_valid;
  logic [ES_TO_MS_WD-1:0] es_to_ms_bus;
  logic                   ms_to_ws_valid;
  logic [MS_TO_WS_WD-1:0] ms_to_ws_bus;
  logic [31:0]            data_sram_rdata;
  logic [MS_TO_DS_WD-1:0] ms_to_ds_bus;

  modport master (
    output ws_allowin,
    output es_to_ms_valid,
    output es_to_ms_bus,
    output data_sram_rdata,
    input  ms_allowin,
    input  ms_to_ws_valid,
    input  ms_to_ws_bus,
    input  ms_to_ds_bus
  );

  modport slave (
    input  ws_allowin,
    input  es_to_ms_valid,
    input  es_to_ms_bus,
    input  data_sram_rdata,
    output ms_allowin,
    output ms_to_ws_valid,
    output ms_to_ws_bus,
    output ms_to_ds_bus
  );

endinterface

// File: rtl/mem_stage.sv
// ----------------------------------------------------------------------------
// mem_stage
//
// Fourth pipeline stage, between execute and write-back. Accepts an
// instruction from execute, completes loads with the synchronous data SRAM
// read data, holds that data across write-back stalls and forms the final
// register-write result. The in-flight write target is fed back to decode
// for hazard detection and bypassing.
//
// Ports:
//   clk    clock
//   reset  synchronous, active-high reset
//   pipe   mem_stage_if.slave (handshakes, buses and SRAM read data)
//
// Build option: SUBWORD_LOAD_EN
//   defined   -> 74-bit input bus carrying load_type; byte/halfword loads are
//                extracted from the read word and sign/zero extended
//   undefined -> 71-bit input bus; loads return the full 32-bit word
// ----------------------------------------------------------------------------
module mem_stage #(
`ifdef SUBWORD_LOAD_EN
  parameter int ES_TO_MS_WD = 74,
`else
  parameter int ES_TO_MS_WD = 71,
`endif
  parameter int MS_TO_WS_WD = 70,
  parameter int MS_TO_DS_WD = 38
) (
  input  logic          clk,
  input  logic          reset,
  mem_stage_if.slave    pipe
);

  // Field layout of the execute-to-memory bus (MSB first).
  typedef struct packed {
`ifdef SUBWORD_LOAD_EN
    logic [2:0]  load_type;
`endif
    logic        res_from_mem;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] result;   // ALU result, or the load address for loads
    logic [31:0] pc;
  } es_to_ms_t;

`ifdef SUBWORD_LOAD_EN
  // Unlisted codes fall through to a full-word load.
  typedef enum logic [2:0] {
    LD_W  = 3'd0,
    LD_B  = 3'd1,
    LD_BU = 3'd2,
    LD_H  = 3'd3,
    LD_HU = 3'd4
  } load_type_e;
`endif

  // --------------------------------------------------------------------------
  // Stage registers
  // --------------------------------------------------------------------------
  logic                   ms_valid;
  logic                   ms_first;     // first cycle this instruction is here
  logic [31:0]            rdata_hold;   // SRAM data kept for stalled loads
  es_to_ms_t              ms_bus_r;

  logic [ES_TO_MS_WD-1:0] es_bus_in;
  logic                   ms_ready_go;
  logic                   ms_allowin;
  logic                   accept;

  logic [31:0]            rdata_eff;
  logic [31:0]            mem_data;
  logic [31:0]            final_result;

  logic [MS_TO_WS_WD-1:0] ws_bus;
  logic [MS_TO_DS_WD-1:0] ds_bus;

  assign es_bus_in   = pipe.es_to_ms_bus;

  // Loads finish in a single cycle here, so the stage is always ready.
  assign ms_ready_go = 1'b1;
  assign ms_allowin  = !ms_valid || (ms_ready_go && pipe.ws_allowin);
  assign accept      = pipe.es_to_ms_valid && ms_allowin;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  // NOTE: the bus register and rdata_hold are reset as well as the valid bit,
  // so no X from an unwritten register can reach the decode feedback path.
  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid   <= 1'b0;
      ms_first   <= 1'b0;
      rdata_hold <= 32'd0;
      ms_bus_r   <= '0;
    end else begin
      if (ms_allowin) begin
        ms_valid <= pipe.es_to_ms_valid;
      end

      if (accept) begin
        ms_bus_r <= es_to_ms_t'(es_bus_in);
        ms_first <= 1'b1;
      end else begin
        ms_first <= 1'b0;
      end

      // The SRAM presents data only in the load's first cycle here; keep a
      // copy so a write-back stall of any length sees the same value. When a
      // new load enters on the same edge, ms_first selects the live data next
      // cycle, so this overwrite never leaks into the new instruction.
      if (ms_valid && ms_first) begin
        rdata_hold <= pipe.data_sram_rdata;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Load data path
  // --------------------------------------------------------------------------
  assign rdata_eff = ms_first ? pipe.data_sram_rdata : rdata_hold;

`ifdef SUBWORD_LOAD_EN
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // NOTE: every combinational output gets a default before any branch, so a
  // missed case can never turn into an inferred latch.
  always_comb begin
    byte_sel = rdata_eff[7:0];
    half_sel = rdata_eff[15:0];
    mem_data = rdata_eff;

    // Byte lane chosen by the low two address bits; halfwords are aligned,
    // so only address bit 1 picks the lane.
    case (ms_bus_r.result[1:0])
      2'd0:    byte_sel = rdata_eff[7:0];
      2'd1:    byte_sel = rdata_eff[15:8];
      2'd2:    byte_sel = rdata_eff[23:16];
      default: byte_sel = rdata_eff[31:24];
    endcase
    half_sel = ms_bus_r.result[1] ? rdata_eff[31:16] : rdata_eff[15:0];

    case (load_type_e'(ms_bus_r.load_type))
      LD_B:    mem_data = {{24{byte_sel[7]}}, byte_sel};
      LD_BU:   mem_data = {24'd0, byte_sel};
      LD_H:    mem_data = {{16{half_sel[15]}}, half_sel};
      LD_HU:   mem_data = {16'd0, half_sel};
      default: mem_data = rdata_eff;
    endcase
  end
`else
  assign mem_data = rdata_eff;
`endif

  assign final_result = ms_bus_r.res_from_mem ? mem_data : ms_bus_r.result;

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign ws_bus = {ms_bus_r.gr_we, ms_bus_r.dest, final_result, ms_bus_r.pc};

  // Decode must never see a write target from an empty stage.
  assign ds_bus = {ms_valid && ms_bus_r.gr_we, ms_bus_r.dest, final_result};

  assign pipe.ms_allowin     = ms_allowin;
  assign pipe.ms_to_ws_valid = ms_valid && ms_ready_go;
  assign pipe.ms_to_ws_bus   = ws_bus;
  assign pipe.ms_to_ds_bus   = ds_bus;

endmodule
